i_fetch_q: RTL and testbench
============================

I_FETCH_Q -- requirements
Module: i_fetch_q

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning address/PC width.
REQ-002 The module SHALL have parameter QDEPTH, default 4, meaning fetch-queue entries (power of 2, >=2).
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-004 The module SHALL use a single clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-005 The module SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- redirect_valid  in  1  branch/jump redirect strobe
- redirect_pc  in  XLEN  redirect target
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction
- inst_pc  out  XLEN  PC of queue head
- inst_ready  in  1  consumer pops head when inst_valid&&inst_ready
- mem_valid  out  1  fetch request, held until mem_done
- mem_addr  out  XLEN  fetch address
- mem_done  in  1  one-cycle response strobe
- mem_inst  in  32  response data, valid with mem_done

Function
REQ-006 The module SHALL have at most one memory request outstanding.
REQ-007 States: IDLE, WAIT_MEM, DISCARD.
- IDLE->WAIT_MEM when queue count < QDEPTH.
- WAIT_MEM->IDLE on mem_done.
- WAIT_MEM->DISCARD on redirect without mem_done.
- DISCARD->IDLE on mem_done.
REQ-008 mem_valid SHALL be 1 exactly in WAIT_MEM and DISCARD; mem_addr SHALL stay stable while mem_valid=1.
REQ-009 On mem_done in WAIT_MEM without redirect, the module SHALL push {pc, mem_inst} and set pc <= pc+4, wrapping modulo 2^XLEN.
REQ-010 inst_valid SHALL equal queue non-empty; inst/inst_pc SHALL come from the head register with no combinational path from mem_inst.
REQ-011 Latency: mem_done at edge N SHALL give inst_valid=1 after edge N when the queue was empty.
REQ-012 Push and pop in the same cycle SHALL leave count unchanged; pop on empty and push on full SHALL never occur.
REQ-013 Redirect SHALL flush the queue, set pc <= redirect_pc, and ignore inst_ready in that cycle.
REQ-014 Redirect takes priority over pop and push.
REQ-015 Data returned in the same cycle as a redirect SHALL be dropped, with state -> IDLE.
REQ-016 Data returned in DISCARD SHALL be dropped.
REQ-017 Redirect in DISCARD SHALL update pc only.
REQ-018 Fetch SHALL resume from the new pc on the next IDLE cycle.

Reset
REQ-019 While rst_n=0, the module SHALL hold: state=IDLE, pc=RESET_PC, count=0, mem_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-020 The first mem_valid=1 SHALL occur after the first clk edge following deassertion.
REQ-021 Reset asserted mid-request SHALL abandon the request without waiting for mem_done.

Configuration
REQ-022 With IFETCH_BR_STALL_EN defined, the module SHALL add input br_done (1) and stop issuing requests after pushing an instruction with opcode 1100011, 1101111 or 1100111.
REQ-023 With IFETCH_BR_STALL_EN defined, the stall SHALL be released by redirect_valid or br_done.
REQ-024 Without IFETCH_BR_STALL_EN, the br_done port SHALL be absent and fetch SHALL continue sequentially.

Structure
REQ-025 Package ifetch_pkg SHALL hold the state enum and opcode constants OP_BRANCH, OP_JAL and OP_JALR.
REQ-026 The queue SHALL be the sub-module ifetch_fifo: parametrised circular buffer with width and depth parameters, push/pop/flush, and wrap-around pointers plus a count.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset release, mem_done one cycle after every request, inst_ready=1 -> inst_pc sequence 0,4,8,12 with one instruction per two cycles.
- inst_ready=0, QDEPTH=4 -> exactly four requests, then mem_valid stays 0; one pop -> one new request to 0x10.
- Redirect to 0x100 while mem_valid=1 at 0x8, mem_done two cycles later -> response dropped, queue empty, next mem_addr=0x100.
- Redirect to 0x200 in the same cycle as mem_done -> no push; next mem_addr=0x200.
- IFETCH_BR_STALL_EN, fetched 0x00001063 -> no further request until br_done pulse, then fetch continues at pc+4.
- rst_n low mid-request at pc=0x40 -> all outputs zero immediately; after release, mem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   fetch_state_e : fetch FSM state encoding
//   OP_BRANCH/OP_JAL/OP_JALR : control-transfer opcodes (inst[6:0])
//   is_ctrl_xfer() : true when an instruction may change the flow of control
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      DISCARD  = 2'd2
   } fetch_state_e;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   function automatic logic is_ctrl_xfer(input logic [31:0] ins);
      return (ins[6:0] == OP_BRANCH) || (ins[6:0] == OP_JAL) || (ins[6:0] == OP_JALR);
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular-buffer FIFO holding fetched {pc, instruction} entries.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   i_push, i_data   : write an entry (ignored when full without a pop)
//   i_pop            : drop the head entry (ignored when empty)
//   i_flush          : empty the queue; wins over push/pop
//   o_data           : head entry, straight from the storage registers
//   o_count, o_empty : occupancy
module ifetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == LP_DEPTH);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!w_full || w_pop);

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/i_fetch_q.sv
// Instruction fetch unit: issues one sequential fetch at a time and buffers
// returned instructions in a small queue for the decoder.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   redirect_valid/redirect_pc : branch/jump redirect, flushes the queue
//   inst_valid/inst/inst_pc    : queue head, popped on inst_valid && inst_ready
//   mem_valid/mem_addr         : fetch request, held until mem_done
//   mem_done/mem_inst          : one-cycle fetch response
//   br_done                    : only with IFETCH_BR_STALL_EN; releases the
//                                fetch stall taken after a control-transfer
//                                instruction is queued
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no request outstanding; issue from pc if queue has room
// WAIT_MEM | request at mem_addr outstanding; response will be queued
// DISCARD  | request outstanding but made stale by a redirect; drop data
module i_fetch_q
   import ifetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              QDEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef IFETCH_BR_STALL_EN
   input  logic            br_done,
`endif
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready,
   output logic            mem_valid,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_done,
   input  logic [31:0]     mem_inst
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(QDEPTH);

   fetch_state_e       r_state;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_mem_addr;
   logic               r_mem_valid;
   logic [XLEN+31:0]   w_head;
   logic [CW-1:0]      w_count;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_issue;
   logic               w_stall;

   // Redirect outranks both ends of the queue in the same cycle.
   assign w_pop   = !w_empty && inst_ready && !redirect_valid;
   assign w_push  = (r_state == WAIT_MEM) && mem_done && !redirect_valid;
   assign w_issue = !redirect_valid && !w_stall && (w_count < LP_DEPTH);

   ifetch_fifo #(
      .WIDTH (XLEN + 32),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  ({r_pc, mem_inst}),
      .o_data  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

`ifdef IFETCH_BR_STALL_EN
   logic r_stall;

   // A newly queued branch/jump wins over a br_done for an older one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               r_stall <= 1'b0;
      else if (redirect_valid)                  r_stall <= 1'b0;
      else if (w_push && is_ctrl_xfer(mem_inst)) r_stall <= 1'b1;
      else if (br_done)                         r_stall <= 1'b0;
   end

   assign w_stall = r_stall;
`else
   assign w_stall = 1'b0;
`endif

   // A redirect seen in IDLE only retargets pc; the fetch starts next cycle
   // so no request is ever issued from the stale pc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_pc        <= RESET_PC;
         r_mem_addr  <= '0;
         r_mem_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (redirect_valid) begin
                  r_pc <= redirect_pc;
               end else if (w_issue) begin
                  r_state     <= WAIT_MEM;
                  r_mem_addr  <= r_pc;
                  r_mem_valid <= 1'b1;
               end
            end
            WAIT_MEM: begin
               if (redirect_valid) begin
                  r_pc <= redirect_pc;
                  if (mem_done) begin
                     r_state     <= IDLE;
                     r_mem_valid <= 1'b0;
                  end else begin
                     r_state <= DISCARD;
                  end
               end else if (mem_done) begin
                  r_pc        <= r_pc + XLEN'(4);
                  r_state     <= IDLE;
                  r_mem_valid <= 1'b0;
               end
            end
            DISCARD: begin
               if (redirect_valid) r_pc <= redirect_pc;
               if (mem_done) begin
                  r_state     <= IDLE;
                  r_mem_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_mem_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mem_valid  = r_mem_valid;
   assign mem_addr   = r_mem_addr;
   assign inst_valid = !w_empty;
   assign inst_pc    = w_head[XLEN+31:32];
   assign inst       = w_head[31:0];

endmodule

// File: tb/tb_i_fetch_q.sv
`timescale 1ns/1ps
module tb_i_fetch_q;

   localparam int          XLEN     = 32;
   localparam int          QDEPTH   = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_done = 1'b0;
   logic [31:0] mem_inst = '0;
   logic        br_done = 1'b0;

   always #5 clk = ~clk;

   i_fetch_q #(.XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
`ifdef IFETCH_BR_STALL_EN
      .br_done        (br_done),
`endif
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .mem_valid      (mem_valid),
      .mem_addr       (mem_addr),
      .mem_done       (mem_done),
      .mem_inst       (mem_inst)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } item_t;

   int tests = 0;
   int fails = 0;

   // Reference model: queue contents, next fetch pc, outstanding request.
   item_t       exp_q[$];
   logic [31:0] model_pc;
   bit          req_open, stale;
   logic [31:0] open_addr;
   int          wait_left;
   bit          l_redir, l_acc;
   logic [31:0] l_rpc;
   item_t       l_item;

   logic [31:0] req_log[$];
   logic [31:0] pop_pc[$];
   int          pop_cyc[$];
   int          cyc = 0;
   int          n_req = 0;
   bit          mon_en = 1'b0;
   item_t       mon_e;

   int          ready_pct, redir_pct, max_delay, br_pct;
   bit          nop_data;
   logic [31:0] hold_addr = 32'hFFFF_FFFF;
   bit          f_rv, f_done, f_rdy, f_br, f_ovr;
   logic [31:0] f_rpc, f_inst;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   task automatic set_knobs(int rdy, int rdr, int dly, int br, bit nop);
      ready_pct = rdy; redir_pct = rdr; max_delay = dly; br_pct = br; nop_data = nop;
      hold_addr = 32'hFFFF_FFFF;
   endtask

   // Monitor: pops the expected queue whenever the DUT hands out its head.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("inst_valid", inst_valid, exp_q.size() != 0);
         if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("head_pc", inst_pc, mon_e.pc);
            check("head_inst", inst, mon_e.ins);
            pop_pc.push_back(inst_pc);
            pop_cyc.push_back(cyc);
         end
      end
   end

   // One clock of stimulus: retire last edge into the model, observe
   // requests, then drive inputs for the next edge.
   task automatic step();
      @(posedge clk); #1;
      cyc++;
      if (l_redir) begin
         exp_q.delete();
         model_pc = l_rpc;
      end else if (l_acc) begin
         exp_q.push_back(l_item);
         model_pc = model_pc + 32'd4;
      end
      l_redir = 1'b0; l_acc = 1'b0;

      if (mem_valid && !req_open) begin
         check("req_addr", mem_addr, model_pc);
         check("req_room", exp_q.size() < QDEPTH, 1'b1);
         req_open  = 1'b1;
         stale     = 1'b0;
         open_addr = mem_addr;
         wait_left = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
         n_req++;
         req_log.push_back(mem_addr);
      end else if (req_open) begin
         check("req_hold", {mem_valid, mem_addr}, {1'b1, open_addr});
      end

      redirect_valid = f_rv || (redir_pct > 0 && int'($urandom_range(99, 0)) < redir_pct);
      if (f_rv) redirect_pc = f_rpc;
      else if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF8;
      else redirect_pc = $urandom & 32'h0000_FFFC;

      mem_done = 1'b0;
      if (req_open) begin
         if (f_done) mem_done = 1'b1;
         else if (open_addr != hold_addr) begin
            if (wait_left == 0) mem_done = 1'b1;
            else wait_left--;
         end
      end
      mem_inst = f_ovr ? f_inst : (nop_data ? 32'h0000_0013 : $urandom);
      if (mem_done) begin
         l_acc    = !stale && !redirect_valid;
         l_item   = {open_addr, mem_inst};
         req_open = 1'b0;
      end
      if (redirect_valid && req_open) stale = 1'b1;
      l_redir = redirect_valid;
      l_rpc   = redirect_pc;

      inst_ready = f_rdy || (int'($urandom_range(99, 0)) < ready_pct);
      br_done    = f_br || (br_pct > 0 && int'($urandom_range(99, 0)) < br_pct);
      f_rv = 1'b0; f_done = 1'b0; f_rdy = 1'b0; f_br = 1'b0; f_ovr = 1'b0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst_n = 1'b0;
      redirect_valid = 1'b0; mem_done = 1'b0; inst_ready = 1'b0; br_done = 1'b0;
      mem_inst = '0; redirect_pc = '0;
      #1;
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_mem_valid", mem_valid, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      repeat (2) @(posedge clk);
      exp_q.delete(); req_log.delete(); pop_pc.delete(); pop_cyc.delete();
      model_pc = RESET_PC; req_open = 1'b0; stale = 1'b0;
      l_redir = 1'b0; l_acc = 1'b0; cyc = 0; n_req = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 mon_en = 1'b1;
   endtask

   task automatic wait_open(logic [31:0] addr, int bound, string name);
      int k = 0;
      while (!(req_open && open_addr == addr) && k < bound) begin
         step();
         k++;
      end
      check(name, {req_open, open_addr}, {1'b1, addr});
   endtask

   task automatic wait_new_req(int bound, string name);
      int k = 0;
      int n0 = n_req;
      while (n_req == n0 && k < bound) begin
         step();
         k++;
      end
      check(name, n_req, n0 + 1);
   endtask

   initial begin
      #2;
      // Sequential fetch, immediate responses, consumer always ready.
      do_reset();
      set_knobs(100, 0, 0, 0, 1'b1);
      repeat (10) step();
      check("s1_pops", pop_pc.size() >= 4, 1'b1);
      if (pop_pc.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("s1_pc", pop_pc[i], 32'(4 * i));
         for (int i = 0; i < 3; i++) check("s1_gap", pop_cyc[i+1] - pop_cyc[i], 2);
      end

      // Consumer stalled: queue fills, fetch stops; one pop frees one slot.
      do_reset();
      set_knobs(0, 0, 0, 0, 1'b1);
      repeat (20) step();
      check("s2_req_cnt", n_req, 4);
      check("s2_idle", mem_valid, 1'b0);
      f_rdy = 1'b1;
      step();
      repeat (6) step();
      check("s2_req_cnt2", n_req, 5);
      check("s2_addr", req_log[$], 32'h10);

      // Redirect while a request is outstanding; late response dropped.
      do_reset();
      set_knobs(0, 0, 0, 0, 1'b1);
      hold_addr = 32'h8;
      wait_open(32'h8, 20, "s3_reach");
      f_rv = 1'b1; f_rpc = 32'h100;
      step();
      step();
      f_done = 1'b1;
      step();
      hold_addr = 32'hFFFF_FFFF;
      step();
      check("s3_empty", inst_valid, 1'b0);
      wait_new_req(10, "s3_new_req");
      check("s3_addr", req_log[$], 32'h100);

      // Redirect coincident with the response: no push.
      do_reset();
      set_knobs(0, 0, 0, 0, 1'b1);
      hold_addr = 32'hC;
      wait_open(32'hC, 20, "s4_reach");
      f_rv = 1'b1; f_rpc = 32'h200; f_done = 1'b1;
      step();
      hold_addr = 32'hFFFF_FFFF;
      step();
      check("s4_empty", inst_valid, 1'b0);
      wait_new_req(10, "s4_new_req");
      check("s4_addr", req_log[$], 32'h200);

`ifdef IFETCH_BR_STALL_EN
      // Branch queued: fetch holds until br_done.
      do_reset();
      set_knobs(100, 0, 0, 0, 1'b1);
      f_ovr = 1'b1; f_inst = 32'h0000_1063;
      step();
      repeat (8) step();
      check("s5_stalled", n_req, 1);
      check("s5_idle", mem_valid, 1'b0);
      f_br = 1'b1;
      step();
      wait_new_req(10, "s5_resume");
      check("s5_addr", req_log[$], 32'h4);
`endif

      // Reset in the middle of a request at 0x40.
      do_reset();
      set_knobs(100, 0, 0, 0, 1'b1);
      hold_addr = 32'h40;
      wait_open(32'h40, 100, "s6_reach");
      hold_addr = 32'hFFFF_FFFF;
      do_reset();
      step();
      check("s6_first", {mem_valid, mem_addr}, {1'b1, RESET_PC});

      // Randomised traffic, then drain.
      do_reset();
`ifdef IFETCH_BR_STALL_EN
      set_knobs(70, 5, 3, 20, 1'b0);
`else
      set_knobs(70, 5, 3, 0, 1'b0);
`endif
      repeat (3000) step();
      set_knobs(100, 0, 0, 0, 1'b1);
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
      $fatal(1);
   end

endmodule
